// File: rtl/csr_access_unit.sv
// Initiator side of the Zicsr read/write port: one read phase, an optional
// write phase, then the old CSR value is returned for rd writeback.
module csr_access_unit #(
  parameter bit RO_CHECK = 1'b1,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [4:0]      req_uimm,
  input  logic            req_rd_is_x0,
  input  logic            flush,
  output logic            csr_rd_en,
  output logic            csr_explicit_rd,
  output logic            csr_wr_en,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  input  logic [XLEN-1:0] csr_rd_data,
  input  logic            csr_illegal,
  output logic            busy,
  output logic            done,
  output logic            rd_we,
  output logic [XLEN-1:0] rd_result,
  output logic            illegal_inst
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            rdx0_q, rdx0_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            ill_q, ill_d;

  logic            wr_intent;
  logic            ro_hit;
  logic [XLEN-1:0] wr_src;

  // op encoding is funct3[1:0]: 01 = write, 10 = set, 11 = clear
  function automatic logic [XLEN-1:0] csr_wdata(input logic [1:0] op,
                                                input logic [XLEN-1:0] src,
                                                input logic [XLEN-1:0] opnd);
    case (op)
      2'b01:   csr_wdata = opnd;
      2'b10:   csr_wdata = src | opnd;
      default: csr_wdata = src & ~opnd;
    endcase
  endfunction

  assign wr_intent = (op_q == 2'b01) || (opnd_q != '0);
  assign ro_hit    = RO_CHECK && (addr_q[11:10] == 2'b11) && wr_intent;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    opnd_d  = opnd_q;
    rdx0_d  = rdx0_q;
    old_d   = old_q;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d   = req_funct3[1:0];
          addr_d = req_addr;
          opnd_d = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_uimm} : req_rs1_data;
          rdx0_d = req_rd_is_x0;
          if (req_funct3[1:0] == 2'b00) ill_d = 1'b1;
          else                          state_d = S_READ;
        end
      end
      S_READ: begin
        old_d = csr_rd_data;
        if (csr_illegal || ro_hit) begin
          state_d = S_IDLE;
          ill_d   = 1'b1;
        end else begin
          state_d = wr_intent ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A kill overrides every transition and drops any pending trap pulse.
    if (flush) begin
      state_d = S_IDLE;
      ill_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      opnd_q  <= '0;
      rdx0_q  <= 1'b0;
      old_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      opnd_q  <= opnd_d;
      rdx0_q  <= rdx0_d;
      old_q   <= old_d;
      ill_q   <= ill_d;
    end
  end

  // In READ the old value is still on the bus; from WRITE on it is captured.
  assign wr_src = (state_q == S_READ) ? csr_rd_data : old_q;

  always_comb begin
    req_ready       = (state_q == S_IDLE);
    busy            = (state_q != S_IDLE);
    csr_rd_en       = (state_q == S_READ);
    csr_explicit_rd = (state_q == S_READ) && !rdx0_q;
    csr_wr_en       = (state_q == S_WRITE);
    csr_addr        = '0;
    csr_wr_data     = '0;
    if (state_q == S_READ || state_q == S_WRITE) begin
      csr_addr    = addr_q;
      csr_wr_data = csr_wdata(op_q, wr_src, opnd_q);
    end
    done         = (state_q == S_DONE) && !flush;
    rd_we        = (state_q == S_DONE) && !flush && !rdx0_q;
    rd_result    = (state_q == S_DONE) ? old_q : '0;
    illegal_inst = ill_q && !flush;
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the core's CSR read/write interface.
- Executes Zicsr instructions handed over by decode: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI and CSRRCI.
- Sequences each access as a fixed read phase followed by an optional write phase on the CSR file's port, then returns the old CSR value for rd writeback.
- Sits between decode/execute and the CSR file. It stalls the pipeline while an access is in flight.

Parameters:
- RO_CHECK, 1, when 1, any intended write to addr[11:10]==2'b11 (read-only CSR space) is flagged illegal and suppressed.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  input  1  global system clock
- rst_n  input  1  global reset, asynchronous, active-low
- req_valid  input  1  decode presents a CSR instruction
- req_ready  output  1  unit idle and able to accept
- req_funct3  input  3  instruction funct3
- req_addr  input  12  CSR address (inst[31:20])
- req_rs1_data  input  32  rs1 register value
- req_uimm  input  5  zimm field (inst[19:15])
- req_rd_is_x0  input  1  destination is x0
- flush  input  1  kill the in-flight access (trap or redirect)
- csr_rd_en  output  1  read enable to CSR file
- csr_explicit_rd  output  1  read has architectural side effects (rd != x0)
- csr_wr_en  output  1  write enable to CSR file
- csr_addr  output  12  CSR address
- csr_wr_data  output  32  write data
- csr_rd_data  input  32  CSR read data, combinational in the same cycle
- csr_illegal  input  1  illegal address or privilege, combinational in the same cycle
- busy  output  1  stall request to pipeline
- done  output  1  one-cycle completion pulse
- rd_we  output  1  write result to rd, qualified by done
- rd_result  output  32  old CSR value
- illegal_inst  output  1  one-cycle pulse; illegal-instruction trap request

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs 0 except req_ready=1. Captured registers cleared.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - req_ready=1 and busy=0.
  - On req_valid, capture funct3, addr, operand and rd_is_x0.
  - The operand is req_rs1_data when funct3[2]=0, otherwise {27'b0, req_uimm}.
  - funct3 of 000 or 100 pulses illegal_inst in the next cycle and the unit stays IDLE.
  - Any other valid funct3 moves to READ.
- READ (1 cycle):
  - Drive csr_rd_en=1 (always, for the existence/privilege check) and csr_explicit_rd = !rd_is_x0. csr_addr holds the captured address.
  - Sample csr_rd_data into old_val and sample csr_illegal.
  - If csr_illegal is set, or the read-only rule applies, go to IDLE and pulse illegal_inst next cycle. No write is issued.
  - Otherwise, if write_intended go to WRITE, else go to DONE.
- write_intended:
  - Always set for RW/RWI.
  - For RS/RC/RSI/RCI, set only when the operand is nonzero. The mask test is on the operand value for immediates; for register forms it is taken as rs1_data != 0.
- WRITE (1 cycle):
  - Drive csr_wr_en=1 with csr_wr_data set by op: RW = operand, RS = old_val | operand, RC = old_val & ~operand.
  - csr_rd_en=0. Go to DONE.
- DONE (1 cycle):
  - done=1, rd_we = !rd_is_x0, rd_result = old_val. Go to IDLE.
- busy=1 in READ, WRITE and DONE. req_ready=1 only in IDLE.
- Latency:
  - Accept to done is 3 cycles with a write, 2 cycles without.
  - Back-to-back requests are accepted on the cycle after DONE.
- csr_addr and csr_wr_data are held stable throughout READ and WRITE. They are 0 when IDLE.
- flush:
  - Takes priority over all transitions: next state is IDLE.
  - Any write not yet driven is never issued. done, rd_we and illegal_inst are suppressed.
  - flush during IDLE together with req_valid means the request is not accepted.
- Reset asserted mid-access: immediate return to IDLE, and csr_wr_en drops asynchronously.
- csr_rd_en and csr_wr_en are never high in the same cycle.

Test Plan:
- CSRRW mscratch(0x340), rs1=0xDEADBEEF, rd=x5, old=0x0: READ with explicit_rd=1, then WRITE data 0xDEADBEEF, then done with rd_result=0x0 and rd_we=1; busy for 3 cycles.
- CSRRS mstatus(0x300) with rs1=x0 (0), old=0x1888: rd_en only, no csr_wr_en; done 2 cycles after accept with rd_result=0x1888.
- CSRRCI mstatus, uimm=8, old=0x1888: wr_data=0x1880.
- CSRRWI rd=x0, uimm=0x1F: explicit_rd=0, wr_data=0x1F; done with rd_we=0.
- CSRRW to 0xC00 (cycle, RO_CHECK=1), and separately to unmapped 0x7FF with csr_illegal=1: illegal_inst pulse, no csr_wr_en, no done.
- flush asserted in READ of a CSRRW: no csr_wr_en, no done, req_ready=1 the next cycle. Also assert rst_n low in WRITE: csr_wr_en falls without waiting for a clock edge.
